// File: rtl/cpu_trace_monitor.sv
// Retired-instruction trace monitor: captures {pc, instr, regw_addr} into a FIFO
// while the CPU runs, and detects stalls (repeated PC) and run timeouts.
module cpu_trace_monitor #(
  parameter int PC_W        = 32,
  parameter int INSTR_W     = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 17,
  parameter int TIMEOUT     = 256,
  parameter int STALL_LIMIT = 4,
  parameter int OVERWRITE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [PC_W-1:0]               pc_in,
  input  logic [INSTR_W-1:0]            instr_in,
  input  logic [4:0]                    regw_addr,
  input  logic                          rd_en,
  output logic [PC_W+INSTR_W+5-1:0]     rd_data,
  output logic                          rd_valid,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [CNT_W-1:0]              instr_count,
  output logic                          running,
  output logic                          halted,
  output logic                          timed_out,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + INSTR_W + 5;
  localparam int RW = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HALT    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [RW-1:0]    REP_ONE   = RW'(1);
  localparam logic [RW-1:0]    REP_HALT  = RW'(STALL_LIMIT);
  localparam logic [AW:0]      FIFO_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      FIFO_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] cycle_next;
  logic [RW-1:0]    rep_cnt;
  logic [RW-1:0]    rep_next;
  logic [PC_W-1:0]  prev_pc;
  logic [PC_W-1:0]  prev_pc_next;
  logic             capture;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             grow;
  logic             write_en;
  logic             drop_oldest;
  logic [AW:0]      count_next;

  // Monitor FSM next-state, cycle/repeat tracking and capture decision
  always_comb begin
    capture      = 1'b0;
    state_next   = state;
    cycle_next   = cycle_cnt;
    rep_next     = rep_cnt;
    prev_pc_next = prev_pc;
    case (state)
      S_IDLE: begin
        if (valid_in) begin
          capture      = 1'b1;
          state_next   = S_RUN;
          cycle_next   = {CNT_W{1'b0}};
          rep_next     = REP_ONE;
          prev_pc_next = pc_in;
        end else begin
          state_next   = S_IDLE;
        end
      end
      S_RUN: begin
        cycle_next = cycle_cnt + CNT_ONE;
        if (valid_in) begin
          capture      = 1'b1;
          prev_pc_next = pc_in;
          rep_next     = (pc_in == prev_pc) ? (rep_cnt + REP_ONE) : REP_ONE;
        end else begin
          rep_next     = rep_cnt;
        end
        // A stall detected on the same edge as the timeout wins
        if (valid_in && (rep_next == REP_HALT)) begin
          state_next = S_HALT;
        end else if (cycle_next == CYC_LAST) begin
          state_next = S_TIMEOUT;
        end else begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  // FIFO control: a pop frees a slot before this edge's push is placed
  always_comb begin
    full        = (fifo_count == FIFO_FULL);
    pop         = rd_en && (fifo_count != {(AW+1){1'b0}});
    grow        = capture && (!full || pop);
    drop_oldest = capture && full && !pop && (OVERWRITE != 0);
    write_en    = grow || drop_oldest;
    if (grow && !pop) begin
      count_next = fifo_count + FIFO_ONE;
    end else if (pop && !grow) begin
      count_next = fifo_count - FIFO_ONE;
    end else begin
      count_next = fifo_count;
    end
  end

  // Trace storage; contents are don't-care outside the pointer window
  always_ff @(posedge clk) begin
    if (!reset && write_en) begin
      mem[wr_ptr] <= {pc_in, instr_in, regw_addr};
    end
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cycle_cnt   <= {CNT_W{1'b0}};
      rep_cnt     <= {RW{1'b0}};
      prev_pc     <= {PC_W{1'b0}};
      wr_ptr      <= {AW{1'b0}};
      rd_ptr      <= {AW{1'b0}};
      fifo_count  <= {(AW+1){1'b0}};
      instr_count <= {CNT_W{1'b0}};
      rd_data     <= {EW{1'b0}};
      rd_valid    <= 1'b0;
      overflow    <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state      <= state_next;
      cycle_cnt  <= cycle_next;
      rep_cnt    <= rep_next;
      prev_pc    <= prev_pc_next;
      fifo_count <= count_next;
      running    <= (state_next == S_RUN);
      halted     <= (state_next == S_HALT);
      timed_out  <= (state_next == S_TIMEOUT);
      rd_valid   <= pop;
      if (write_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop || drop_oldest) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_data <= mem[rd_ptr];
      end
      if (capture && (instr_count != CNT_SAT)) begin
        instr_count <= instr_count + CNT_ONE;
      end
      if (capture && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Randomized and directed bench for cpu_trace_monitor: three instances (DEPTH 16,
// DEPTH 4 drop-new, DEPTH 4 drop-oldest) run in lockstep against a queue-based model.
module tb_cpu_trace_monitor;

  localparam int EW      = 69;
  localparam int CW      = 17;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int TMO     = 256;
  localparam int STALL   = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_TMO = 3;

  logic        clk = 1'b0;
  logic        reset, valid_in, rd_en;
  logic [31:0] pc_in, instr_in;
  logic [4:0]  regw_addr;

  logic [EW-1:0] rdd_o [3];
  logic          rdv_o [3];
  logic [CW-1:0] ic_o  [3];
  logic          run_o [3];
  logic          hlt_o [3];
  logic          tmo_o [3];
  logic          ovf_o [3];
  logic [4:0]    fc0;
  logic [2:0]    fc1, fc2;
  logic [4:0]    fc_o  [3];

  int checks = 0;
  int failures = 0;

  // model state
  logic [EW-1:0] mq [3][$];
  int            depth_m [3] = '{16, 4, 4};
  bit            ow_m    [3] = '{1'b0, 1'b0, 1'b1};
  int            m_st    [3];
  int            m_age   [3];
  int            m_reps  [3];
  logic [31:0]   m_prev  [3];
  int            m_ic    [3];
  bit            m_ovf   [3];
  bit            m_rdv   [3];
  logic [EW-1:0] m_rdd   [3];
  logic [EW-1:0] last_e;

  always #5 clk = ~clk;

  always_comb begin
    fc_o[0] = fc0;
    fc_o[1] = {2'b00, fc1};
    fc_o[2] = {2'b00, fc2};
  end

  cpu_trace_monitor u0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .regw_addr(regw_addr), .rd_en(rd_en), .rd_data(rdd_o[0]), .rd_valid(rdv_o[0]),
    .fifo_count(fc0), .instr_count(ic_o[0]), .running(run_o[0]), .halted(hlt_o[0]),
    .timed_out(tmo_o[0]), .overflow(ovf_o[0]));

  cpu_trace_monitor #(.DEPTH(4), .OVERWRITE(0)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .regw_addr(regw_addr), .rd_en(rd_en), .rd_data(rdd_o[1]), .rd_valid(rdv_o[1]),
    .fifo_count(fc1), .instr_count(ic_o[1]), .running(run_o[1]), .halted(hlt_o[1]),
    .timed_out(tmo_o[1]), .overflow(ovf_o[1]));

  cpu_trace_monitor #(.DEPTH(4), .OVERWRITE(1)) u2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .regw_addr(regw_addr), .rd_en(rd_en), .rd_data(rdd_o[2]), .rd_valid(rdv_o[2]),
    .fifo_count(fc2), .instr_count(ic_o[2]), .running(run_o[2]), .halted(hlt_o[2]),
    .timed_out(tmo_o[2]), .overflow(ovf_o[2]));

  task automatic model_step(input int d, input bit v, input logic [31:0] p,
                            input logic [EW-1:0] e, input bit rde, input bit rst);
    bit cap;
    if (rst) begin
      m_st[d] = M_IDLE; mq[d].delete(); m_ic[d] = 0; m_ovf[d] = 1'b0;
      m_rdv[d] = 1'b0; m_rdd[d] = '0; m_reps[d] = 0; m_age[d] = 0;
      return;
    end
    cap = v && (m_st[d] == M_IDLE || m_st[d] == M_RUN);
    if (rde && mq[d].size() > 0) begin
      m_rdd[d] = mq[d].pop_front();
      m_rdv[d] = 1'b1;
    end else begin
      m_rdv[d] = 1'b0;
    end
    if (cap) begin
      if (mq[d].size() < depth_m[d]) begin
        mq[d].push_back(e);
      end else begin
        m_ovf[d] = 1'b1;
        if (ow_m[d]) begin
          mq[d].delete(0);
          mq[d].push_back(e);
        end
      end
      if (m_ic[d] < CNT_MAX) m_ic[d]++;
    end
    if (m_st[d] == M_IDLE) begin
      if (v) begin
        m_st[d] = M_RUN; m_age[d] = 1; m_reps[d] = 1; m_prev[d] = p;
      end
    end else if (m_st[d] == M_RUN) begin
      m_age[d]++;
      if (v) begin
        m_reps[d] = (p == m_prev[d]) ? m_reps[d] + 1 : 1;
        m_prev[d] = p;
      end
      if (v && m_reps[d] == STALL) m_st[d] = M_HALT;
      else if (m_age[d] == TMO) m_st[d] = M_TMO;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample after the edge
  task automatic cycle(input bit v, input logic [31:0] p, input bit rde, input bit rst);
    logic [31:0] ins;
    logic [4:0]  ra;
    ins = $urandom;
    ra  = 5'($urandom);
    valid_in = v; pc_in = p; instr_in = ins; regw_addr = ra; rd_en = rde; reset = rst;
    last_e = {p, ins, ra};
    for (int d = 0; d < 3; d++) model_step(d, v, p, last_e, rde, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (fc_o[d] !== 5'd0 || ic_o[d] !== 17'd0 || rdv_o[d] !== 1'b0 || rdd_o[d] !== 69'd0 ||
          run_o[d] !== 1'b0 || hlt_o[d] !== 1'b0 || tmo_o[d] !== 1'b0 || ovf_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: got fc=%0d ic=%0d rdv=%b run=%b hlt=%b tmo=%b ovf=%b want all 0",
                 d, fc_o[d], ic_o[d], rdv_o[d], run_o[d], hlt_o[d], tmo_o[d], ovf_o[d]);
      end
    end
  endtask

  task automatic test_sequential;
    logic [EW-1:0] e [3];
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'(k * 4), 1'b0, 1'b0);
      e[k] = last_e;
    end
    checks++;
    if (ic_o[0] !== 17'd3 || run_o[0] !== 1'b1 || fc0 !== 5'd3) begin
      failures++;
      $display("FAIL seq_state: got ic=%0d run=%b fc=%0d want ic=3 run=1 fc=3", ic_o[0], run_o[0], fc0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (rdv_o[0] !== 1'b1 || rdd_o[0][68:37] !== 32'(k * 4) || rdd_o[0] !== e[k]) begin
        failures++;
        $display("FAIL seq_pop%0d: got v=%b data=%h want v=1 data=%h", k, rdv_o[0], rdd_o[0], e[k]);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (rdv_o[0] !== 1'b0 || rdd_o[0] !== e[2]) begin
      failures++;
      $display("FAIL seq_empty_pop: got v=%b data=%h want v=0 data=%h", rdv_o[0], rdd_o[0], e[2]);
    end
  endtask

  task automatic test_halt;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h20, 1'b0, 1'b0);
      if (k == 2) begin
        checks++;
        if (hlt_o[0] !== 1'b0 || run_o[0] !== 1'b1) begin
          failures++;
          $display("FAIL halt_early: got hlt=%b run=%b want hlt=0 run=1", hlt_o[0], run_o[0]);
        end
      end
    end
    checks++;
    if (hlt_o[0] !== 1'b1 || run_o[0] !== 1'b0 || fc0 !== 5'd4) begin
      failures++;
      $display("FAIL halt: got hlt=%b run=%b fc=%0d want hlt=1 run=0 fc=4", hlt_o[0], run_o[0], fc0);
    end
    cycle(1'b1, 32'h20, 1'b0, 1'b0);
    checks++;
    if (ic_o[0] !== 17'd4 || fc0 !== 5'd4 || hlt_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL halt_ignore: got ic=%0d fc=%0d hlt=%b want ic=4 fc=4 hlt=1", ic_o[0], fc0, hlt_o[0]);
    end
  endtask

  task automatic test_overflow;
    logic [EW-1:0] e [6];
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 32'(32'h100 + k * 4), 1'b0, 1'b0);
      e[k] = last_e;
    end
    checks++;
    if (ovf_o[1] !== 1'b1 || ovf_o[2] !== 1'b1 || ovf_o[0] !== 1'b0 ||
        fc1 !== 3'd4 || fc2 !== 3'd4 || fc0 !== 5'd6) begin
      failures++;
      $display("FAIL ovf_flags: got ovf=%b%b%b fc=%0d/%0d/%0d want ovf=0,1,1 fc=6/4/4",
               ovf_o[0], ovf_o[1], ovf_o[2], fc0, fc1, fc2);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (rdd_o[1] !== e[k] || rdd_o[2] !== e[k + 2]) begin
        failures++;
        $display("FAIL ovf_pop%0d: got drop_new=%h drop_old=%h want %h / %h",
                 k, rdd_o[1], rdd_o[2], e[k], e[k + 2]);
      end
    end
  endtask

  task automatic test_full_push_pop;
    logic [EW-1:0] first;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'(32'h200 + k * 4), 1'b0, 1'b0);
      if (k == 0) first = last_e;
    end
    cycle(1'b1, 32'h300, 1'b1, 1'b0);
    checks++;
    if (fc1 !== 3'd4 || fc2 !== 3'd4 || ovf_o[1] !== 1'b0 || ovf_o[2] !== 1'b0 ||
        rdd_o[1] !== first || rdd_o[2] !== first || rdv_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL full_push_pop: got fc=%0d/%0d ovf=%b%b data=%h want fc=4/4 ovf=00 data=%h",
               fc1, fc2, ovf_o[1], ovf_o[2], rdd_o[1], first);
    end
  endtask

  task automatic test_timeout;
    int ic_before;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      cycle((i == 0) ? 1'b1 : 1'($urandom), 32'(32'h1000 + i * 4), 1'b0, 1'b0);
      if (i == TMO - 2) begin
        checks++;
        if (tmo_o[0] !== 1'b0 || run_o[0] !== 1'b1) begin
          failures++;
          $display("FAIL tmo_early: got tmo=%b run=%b want tmo=0 run=1", tmo_o[0], run_o[0]);
        end
      end
    end
    checks++;
    if (tmo_o[0] !== 1'b1 || run_o[0] !== 1'b0 || ic_o[0] !== 17'(m_ic[0])) begin
      failures++;
      $display("FAIL tmo: got tmo=%b run=%b ic=%0d want tmo=1 run=0 ic=%0d",
               tmo_o[0], run_o[0], ic_o[0], m_ic[0]);
    end
    ic_before = m_ic[0];
    cycle(1'b1, 32'h5000, 1'b0, 1'b0);
    checks++;
    if (ic_o[0] !== 17'(ic_before) || tmo_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL tmo_ignore: got ic=%0d tmo=%b want ic=%0d tmo=1", ic_o[0], tmo_o[0], ic_before);
    end
  endtask

  task automatic test_reset_mid_run;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'(32'h40 + k * 4), 1'b0, 1'b0);
    checks++;
    if (fc0 !== 5'd3 || run_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL midrun_pre: got fc=%0d run=%b want fc=3 run=1", fc0, run_o[0]);
    end
    cycle(1'b1, 32'h80, 1'b1, 1'b1);
    checks++;
    if (fc0 !== 5'd0 || ic_o[0] !== 17'd0 || run_o[0] !== 1'b0 || rdv_o[0] !== 1'b0 ||
        rdd_o[0] !== 69'd0 || ovf_o[0] !== 1'b0 || hlt_o[0] !== 1'b0 || tmo_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: got fc=%0d ic=%0d run=%b rdv=%b want all 0", fc0, ic_o[0], run_o[0], rdv_o[0]);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (rdv_o[0] !== 1'b0 || fc0 !== 5'd0 || run_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL midrun_pop: got rdv=%b fc=%0d run=%b want 0 0 0", rdv_o[0], fc0, run_o[0]);
    end
  endtask

  task automatic test_random;
    logic [31:0] pcs [4];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, pcs[$urandom_range(0, 3)],
            $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (rdv_o[d] !== m_rdv[d] || rdd_o[d] !== m_rdd[d] || fc_o[d] !== 5'(mq[d].size()) ||
            ic_o[d] !== 17'(m_ic[d]) || ovf_o[d] !== m_ovf[d] ||
            run_o[d] !== (m_st[d] == M_RUN) || hlt_o[d] !== (m_st[d] == M_HALT) ||
            tmo_o[d] !== (m_st[d] == M_TMO)) begin
          failures++;
          $display("FAIL random[%0d] cyc%0d: got rdv=%b fc=%0d ic=%0d ovf=%b st=%b%b%b data=%h want rdv=%b fc=%0d ic=%0d ovf=%b st=%0d data=%h",
                   d, i, rdv_o[d], fc_o[d], ic_o[d], ovf_o[d], run_o[d], hlt_o[d], tmo_o[d], rdd_o[d],
                   m_rdv[d], mq[d].size(), m_ic[d], m_ovf[d], m_st[d], m_rdd[d]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; rd_en = 1'b0;
    pc_in = 32'h0; instr_in = 32'h0; regw_addr = 5'd0;
    test_reset;
    test_sequential;
    test_halt;
    test_overflow;
    test_full_push_pop;
    test_timeout;
    test_reset_mid_run;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
